// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions.
//   XLEN / INSTR_W      : datapath widths
//   RESET_PC_DEFAULT    : default PC after reset
//   TRAP_VECTOR_DEFAULT : default PC for a misaligned redirect target
//   fetch_entry_t       : one fetched {pc, instr} pair held in the fetch buffer
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT    = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's external signals: instruction memory port,
// execute redirect request, decode handshake and misaligned-target exception.
//   master : the fetch unit
//   slave  : the surrounding pipeline (imem, execute, decode)
interface fetch_unit_if;
    import riscv_pkg::*;

    logic [XLEN-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;

    logic               redirect;
    logic [XLEN-1:0]    redirect_pc;

    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [XLEN-1:0]    id_pc;
    logic [XLEN-1:0]    id_pc_plus4;

    logic               exc_misaligned;
    logic [XLEN-1:0]    exc_badaddr;

    modport master (
        output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
               exc_misaligned, exc_badaddr,
        input  imem_data, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
               exc_misaligned, exc_badaddr,
        output imem_data, redirect, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs.
//   clk, reset : clock, asynchronous active-low reset
//   push/pop   : write wr_data / advance the head; both may occur together
//   flush      : empties the FIFO and rewinds both pointers; wins over push/pop
//   rd_data    : entry at the head (stale contents when empty)
//   full/empty : occupancy flags
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output fetch_entry_t rd_data,
    output logic         full,
    output logic         empty
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;

    // NOTE: the storage is reset too, because the head entry is visible on the
    // decode outputs and must read as zero straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == 2'(DEPTH));
    assign empty   = (count == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Program-counter generation and instruction fetch stage.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : fetch_unit_if.master -- imem_addr/imem_data to instruction memory,
//           redirect/redirect_pc from execute, id_* valid/ready toward decode,
//           exc_misaligned pulse and exc_badaddr for bad redirect targets
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT,
    parameter int              DEPTH       = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    logic [XLEN-1:0] pc_q;
    logic            exc_misaligned_q;
    logic [XLEN-1:0] exc_badaddr_q;

    fetch_entry_t    head;
    logic            full;
    logic            empty;
    logic            id_valid;
    logic            push;
    logic            pop;

    // A redirect discards this cycle's fetch; a full buffer can still accept
    // a new entry when decode is draining the head on the same edge.
    assign id_valid = !empty;
    assign pop      = id_valid & bus.id_ready;
    assign push     = !bus.redirect & (!full | pop);

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (bus.redirect),
        .wr_data ('{pc: pc_q, instr: bus.imem_data}),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // NOTE: every register here is written with <= so all of them update
    // from the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q             <= RESET_PC;
            exc_misaligned_q <= 1'b0;
            exc_badaddr_q    <= '0;
        end else begin
            exc_misaligned_q <= 1'b0;
            if (bus.redirect) begin
                if (is_misaligned(bus.redirect_pc)) begin
                    pc_q             <= TRAP_VECTOR;
                    exc_misaligned_q <= 1'b1;
                    exc_badaddr_q    <= bus.redirect_pc;
                end else begin
                    pc_q <= bus.redirect_pc;
                end
            end else if (push) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    assign bus.imem_addr      = pc_q;
    assign bus.id_valid       = id_valid;
    assign bus.id_instr       = head.instr;
    assign bus.id_pc          = head.pc;
    // Zero while empty so the whole decode bundle reads zero out of reset.
    assign bus.id_pc_plus4    = id_valid ? head.pc + 32'd4 : '0;
    assign bus.exc_misaligned = exc_misaligned_q;
    assign bus.exc_badaddr    = exc_badaddr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Instruction memory returns its own address.
module tb_fetch_unit;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    fetch_unit_if bus ();

    fetch_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_data = bus.imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        bus.id_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        #3;
        n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.id_valid); end
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
        n_cmp++; if (bus.id_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", bus.id_pc); end
        n_cmp++; if (bus.id_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", bus.id_instr); end
        n_cmp++; if (bus.id_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL reset_plus4: got %h want 0", bus.id_pc_plus4); end
        n_cmp++; if (bus.exc_misaligned !== 1'b0) begin n_err++; $display("FAIL reset_exc: got %b want 0", bus.exc_misaligned); end
        n_cmp++; if (bus.exc_badaddr !== 32'h0) begin n_err++; $display("FAIL reset_bad: got %h want 0", bus.exc_badaddr); end
    endtask

    task automatic test_stream();
        step();
        bus.id_ready = 1'b1;
        reset        = 1'b1;
        #2;
        n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL stream_prefetch_valid: got %b want 0", bus.id_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.id_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.id_valid); end
            n_cmp++; if (bus.id_pc !== 32'(4 * i)) begin n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", i, bus.id_pc, 32'(4 * i)); end
            n_cmp++; if (bus.id_instr !== 32'(4 * i)) begin n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", i, bus.id_instr, 32'(4 * i)); end
            n_cmp++; if (bus.id_pc_plus4 !== 32'(4 * i + 4)) begin n_err++; $display("FAIL stream_plus4[%0d]: got %h want %h", i, bus.id_pc_plus4, 32'(4 * i + 4)); end
        end
    endtask

    task automatic test_stall();
        reset        = 1'b0;
        bus.id_ready = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (bus.imem_addr !== (i == 0 ? 32'h4 : 32'h8)) begin n_err++; $display("FAIL stall_addr[%0d]: got %h want %h", i, bus.imem_addr, (i == 0 ? 32'h4 : 32'h8)); end
            n_cmp++; if (bus.id_pc !== 32'h0 || bus.id_valid !== 1'b1) begin n_err++; $display("FAIL stall_head[%0d]: got pc %h valid %b want pc 0 valid 1", i, bus.id_pc, bus.id_valid); end
        end
        bus.id_ready = 1'b1;
        step();
        n_cmp++; if (bus.id_pc !== 32'h4 || bus.imem_addr !== 32'hC) begin n_err++; $display("FAIL drain_0: got pc %h addr %h want pc 4 addr c", bus.id_pc, bus.imem_addr); end
        step();
        n_cmp++; if (bus.id_pc !== 32'h8 || bus.imem_addr !== 32'h10) begin n_err++; $display("FAIL drain_1: got pc %h addr %h want pc 8 addr 10", bus.id_pc, bus.imem_addr); end
    endtask

    // Buffer stays full: pc_q runs exactly two words ahead of the head.
    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (bus.id_pc !== 32'(12 + 4 * i)) begin n_err++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, bus.id_pc, 32'(12 + 4 * i)); end
            n_cmp++; if (bus.imem_addr !== 32'(20 + 4 * i)) begin n_err++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, bus.imem_addr, 32'(20 + 4 * i)); end
        end
    endtask

    task automatic test_redirect();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %b want 0", bus.id_valid); end
        n_cmp++; if (bus.imem_addr !== 32'h40) begin n_err++; $display("FAIL redir_addr: got %h want 40", bus.imem_addr); end
        step();
        n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h40 || bus.id_instr !== 32'h40) begin n_err++; $display("FAIL redir_first: got valid %b pc %h instr %h want 1 40 40", bus.id_valid, bus.id_pc, bus.id_instr); end
        step();
        n_cmp++; if (bus.id_pc !== 32'h44) begin n_err++; $display("FAIL redir_second: got %h want 44", bus.id_pc); end
    endtask

    task automatic test_misaligned();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h42;
        step();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.exc_misaligned !== 1'b1) begin n_err++; $display("FAIL mis_pulse: got %b want 1", bus.exc_misaligned); end
        n_cmp++; if (bus.exc_badaddr !== 32'h42) begin n_err++; $display("FAIL mis_bad: got %h want 42", bus.exc_badaddr); end
        n_cmp++; if (bus.imem_addr !== 32'h100 || bus.id_valid !== 1'b0) begin n_err++; $display("FAIL mis_trap: got addr %h valid %b want 100 0", bus.imem_addr, bus.id_valid); end
        step();
        n_cmp++; if (bus.exc_misaligned !== 1'b0) begin n_err++; $display("FAIL mis_one_cycle: got %b want 0", bus.exc_misaligned); end
        n_cmp++; if (bus.exc_badaddr !== 32'h42) begin n_err++; $display("FAIL mis_bad_hold: got %h want 42", bus.exc_badaddr); end
        n_cmp++; if (bus.id_pc !== 32'h100 || bus.id_valid !== 1'b1) begin n_err++; $display("FAIL mis_first: got pc %h valid %b want 100 1", bus.id_pc, bus.id_valid); end
    endtask

    task automatic test_redirect_pair();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h43;
        step();
        n_cmp++; if (bus.exc_misaligned !== 1'b1 || bus.exc_badaddr !== 32'h43 || bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL pair_first: got exc %b bad %h addr %h want 1 43 100", bus.exc_misaligned, bus.exc_badaddr, bus.imem_addr); end
        bus.redirect_pc = 32'h80;
        step();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.exc_misaligned !== 1'b0 || bus.exc_badaddr !== 32'h43 || bus.imem_addr !== 32'h80) begin n_err++; $display("FAIL pair_last: got exc %b bad %h addr %h want 0 43 80", bus.exc_misaligned, bus.exc_badaddr, bus.imem_addr); end
        n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL pair_flush: got %b want 0", bus.id_valid); end
        step();
        n_cmp++; if (bus.id_pc !== 32'h80) begin n_err++; $display("FAIL pair_pc: got %h want 80", bus.id_pc); end
    endtask

    task automatic test_wrap();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        step();
        n_cmp++; if (bus.id_pc !== 32'hFFFF_FFFC || bus.id_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_head: got pc %h plus4 %h want fffffffc 0", bus.id_pc, bus.id_pc_plus4); end
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", bus.imem_addr); end
    endtask

    // Buffer holds one entry here (streaming with id_ready=1).
    task automatic test_reset_mid();
        step();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", bus.id_valid); end
        n_cmp++; if (bus.imem_addr !== 32'h0 || bus.id_pc !== 32'h0) begin n_err++; $display("FAIL async_state: got addr %h pc %h want 0 0", bus.imem_addr, bus.id_pc); end
        reset = 1'b1;
        step();
        n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.imem_addr !== 32'h4) begin n_err++; $display("FAIL restart: got valid %b pc %h addr %h want 1 0 4", bus.id_valid, bus.id_pc, bus.imem_addr); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_redirect();
        test_misaligned();
        test_redirect_pair();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Program-counter generation and instruction fetch stage. It sits directly upstream of the word-addressed instruction memory: it drives the fetch address and captures the returned instruction word. Fetched {pc, instr} pairs go into a 2-entry buffer. Decode drains the buffer through a valid/ready handshake. Branch/jump redirects from execute flush the buffer and reload the PC; misaligned redirect targets trap to a fixed vector.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded when a redirect target is misaligned
DEPTH, 2, fetch buffer entries (fixed at 2; count is 2 bits)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low (0 = reset asserted)
imem_addr  output  32  fetch address to instruction memory, always equal to pc_q
imem_data  input  32  instruction word returned combinationally for imem_addr
redirect  input  1  execute requests PC change this cycle
redirect_pc  input  32  redirect target
id_valid  output  1  buffer head holds a valid instruction
id_ready  input  1  decode accepts head this cycle
id_instr  output  32  head instruction
id_pc  output  32  head PC
id_pc_plus4  output  32  head PC + 4
exc_misaligned  output  1  one-cycle pulse: redirect target had bits[1:0] != 0
exc_badaddr  output  32  offending target; holds until the next misaligned event

Behaviour:
- Reset (reset=0, async): pc_q=RESET_PC, count=0, rd_ptr=wr_ptr=0, exc_misaligned=0, exc_badaddr=0. Consequently id_valid=0 and id_instr/id_pc/id_pc_plus4=0.
- imem_addr = pc_q, combinational; no other logic in that path.
- pop = id_valid & id_ready. push = !redirect & (count<2 | pop).
- Normal cycle, no redirect, on the rising edge:
  - If push: write {pc_q, imem_data} at wr_ptr; pc_q <= pc_q+4; wr_ptr toggles.
  - If pop: rd_ptr toggles.
  - count += push - pop.
- Full (count=2) and no pop: no push; pc_q holds. Full with pop: push and pop in the same cycle; count stays 2.
- Empty: id_valid=0. Outputs show the stale entry at rd_ptr; decode must ignore them.
- No bypass: an instruction fetched in cycle N appears on id_* in cycle N+1 at the earliest. Fetch-to-decode latency is 1 cycle.
- Redirect (highest priority; overrides push and pop on the same edge):
  - count<=0, rd_ptr<=0, wr_ptr<=0. Any pop that cycle is discarded.
  - If redirect_pc[1:0]==0: pc_q<=redirect_pc.
  - Else: pc_q<=TRAP_VECTOR, exc_misaligned<=1 for exactly one cycle, exc_badaddr<=redirect_pc.
  - First new-path instruction is fetched the cycle after the redirect and is visible on id_* the cycle after that.
- Back-to-back redirects: the last one wins; each misaligned one pulses exc_misaligned.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 silently.
- Reset mid-operation: all state returns to reset values immediately (async), with no partial push.
- The first fetch occurs on the first rising edge with reset=1, at RESET_PC.

Decomposition:
- Shared package riscv_pkg: XLEN=32, INSTR_W=32, constants RESET_PC_DEFAULT and TRAP_VECTOR_DEFAULT, typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- One natural sub-module: fetch_buffer, a 2-entry FIFO with push/pop/flush, count, full and empty. fetch_unit owns the PC register, the redirect/trap logic and the exception outputs.

Test Plan:
- Reset release, id_ready=1, imem preloaded with words = address: id_pc goes 0x0, 0x4, 0x8 on consecutive cycles; first id_valid one cycle after the first fetch edge; id_pc_plus4 = id_pc+4.
- id_ready=0 for 5 cycles after reset: count reaches 2, imem_addr holds at 0x8. On id_ready=1, entries 0x0 and 0x4 drain in order, fetching resumes at 0x8, and nothing is lost or duplicated.
- Full buffer with id_ready=1 held: simultaneous push/pop every cycle, count stays 2, id_pc increments by 4 each cycle.
- Redirect to 0x40 while count=2 and id_ready=1: next cycle id_valid=0 and imem_addr=0x40; following cycle id_pc=0x40. Pre-redirect entries are never presented again.
- Redirect to 0x42: exc_misaligned=1 for one cycle, exc_badaddr=0x42, imem_addr=0x100, next id_pc=0x100.
- Assert reset mid-stream with count=1: id_valid drops immediately, no clock needed. After release, fetch restarts at RESET_PC.
